// File: rtl/axi_pkg.sv
// AXI4 response codes and the default channel/request/response structs used
// by the error slave and its bench.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned UserWidth = 1;

    typedef logic [IdWidth-1:0]     id_t;
    typedef logic [AddrWidth-1:0]   addr_t;
    typedef logic [DataWidth-1:0]   data_t;
    typedef logic [DataWidth/8-1:0] strb_t;
    typedef logic [UserWidth-1:0]   user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

// File: rtl/axi_decerr_fifo.sv
// Small synchronous FIFO with registered full/empty flags; a push while full is
// dropped even if a pop happens in the same cycle.
module axi_decerr_fifo #(
    parameter int unsigned DataWidth = 32'd8,
    parameter int unsigned Depth     = 32'd4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 test_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned     CntW    = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 full_q, empty_q;
    logic                 do_push, do_pop;
    logic                 unused_test;

    // No clock gating cell in this FIFO, so the test-mode input has no effect.
    assign unused_test = test_i;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == FullCnt);
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/axi_decerr_slv.sv
// Terminating AXI4 slave for unmapped addresses: swallows every request and
// answers each write with one B and each read with len+1 R beats, all with RespCode.
module axi_decerr_slv #(
    parameter int unsigned AxiIdWidth   = 32'd4,
    parameter int unsigned AxiDataWidth = 32'd64,
    parameter type         axi_req_t    = axi_pkg::req_t,
    parameter type         axi_resp_t   = axi_pkg::resp_t,
    parameter int unsigned MaxTrans     = 32'd4,
    parameter logic [1:0]  RespCode     = axi_pkg::RESP_DECERR,
    parameter logic [63:0] RespData     = 64'hCA11AB1EBADCAB1E
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      test_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
);

    localparam int unsigned               DataReps = (AxiDataWidth + 63) / 64;
    localparam logic [DataReps*64-1:0]    DataPat  = {DataReps{RespData}};
    localparam logic [AxiDataWidth-1:0]   RData    = DataPat[AxiDataWidth-1:0];

    typedef enum logic {R_IDLE, R_SEND} r_state_e;

    logic                    out_en_q;
    logic                    aw_full, aw_empty, aw_push, aw_pop;
    logic [AxiIdWidth-1:0]   aw_head;
    logic                    b_full, b_empty, b_push, b_pop;
    logic [AxiIdWidth-1:0]   b_head;
    logic                    ar_full, ar_empty, ar_push, ar_pop;
    logic [AxiIdWidth+7:0]   ar_head;
    logic                    aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last;
    r_state_e                state_q, state_d;
    logic [AxiIdWidth-1:0]   id_q, id_d;
    logic [7:0]              len_q, len_d, cnt_q, cnt_d;
    logic                    unused_req;

    // Only IDs, lengths, valids, w.last and readies matter; the rest is dropped.
    assign unused_req = ^slv_req_i;

    // Keeps the readies low for one extra cycle after reset releases.
    always_ff @(posedge clk_i) begin
        if (rst_i) out_en_q <= 1'b0;
        else       out_en_q <= 1'b1;
    end

    assign aw_ready = out_en_q & ~aw_full;
    assign aw_push  = slv_req_i.aw_valid & aw_ready;
    assign w_ready  = ~aw_empty & ~b_full;
    assign aw_pop   = slv_req_i.w_valid & w_ready & slv_req_i.w.last;
    assign b_push   = aw_pop;
    assign b_valid  = ~b_empty;
    assign b_pop    = b_valid & slv_req_i.b_ready;
    assign ar_ready = out_en_q & ~ar_full;
    assign ar_push  = slv_req_i.ar_valid & ar_ready;

    axi_decerr_fifo #(.DataWidth(AxiIdWidth), .Depth(MaxTrans)) i_aw_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .test_i  (test_i),
        .push_i  (aw_push),
        .data_i  (slv_req_i.aw.id),
        .pop_i   (aw_pop),
        .data_o  (aw_head),
        .full_o  (aw_full),
        .empty_o (aw_empty)
    );

    axi_decerr_fifo #(.DataWidth(AxiIdWidth), .Depth(MaxTrans)) i_b_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .test_i  (test_i),
        .push_i  (b_push),
        .data_i  (aw_head),
        .pop_i   (b_pop),
        .data_o  (b_head),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    axi_decerr_fifo #(.DataWidth(AxiIdWidth + 8), .Depth(MaxTrans)) i_ar_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .test_i  (test_i),
        .push_i  (ar_push),
        .data_i  ({slv_req_i.ar.id, slv_req_i.ar.len}),
        .pop_i   (ar_pop),
        .data_o  (ar_head),
        .full_o  (ar_full),
        .empty_o (ar_empty)
    );

    assign r_valid = (state_q == R_SEND);
    assign r_last  = (cnt_q == len_q);

    // R generator: one burst at a time, cnt_q stops at len_q so it never wraps.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ar_pop  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (!ar_empty) begin
                    {id_d, len_d} = ar_head;
                    cnt_d         = '0;
                    ar_pop        = 1'b1;
                    state_d       = R_SEND;
                end
            end
            R_SEND: begin
                if (slv_req_i.r_ready) begin
                    if (r_last) state_d = R_IDLE;
                    else        cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        id_q  <= id_d;
        len_q <= len_d;
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.b_valid  = b_valid;
        slv_resp_o.b.id     = b_head;
        slv_resp_o.b.resp   = RespCode;
        slv_resp_o.r_valid  = r_valid;
        slv_resp_o.r.id     = id_q;
        slv_resp_o.r.data   = RData;
        slv_resp_o.r.resp   = RespCode;
        slv_resp_o.r.last   = r_last;
    end

endmodule

// File: tb/tb_axi_decerr_slv.sv
// Directed bench for axi_decerr_slv: one task per scenario, inputs driven 1 ns
// after the rising edge and outputs checked in the same window.
module tb_axi_decerr_slv;

    localparam logic [63:0] RDATA = 64'hCA11AB1EBADCAB1E;

    logic           clk = 1'b0;
    logic           rst;
    logic           test;
    axi_pkg::req_t  req;
    axi_pkg::resp_t resp;
    int             n_cmp = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    axi_decerr_slv #(
        .AxiIdWidth   (4),
        .AxiDataWidth (64),
        .axi_req_t    (axi_pkg::req_t),
        .axi_resp_t   (axi_pkg::resp_t),
        .MaxTrans     (4),
        .RespCode     (axi_pkg::RESP_DECERR),
        .RespData     (RDATA)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .test_i     (test),
        .slv_req_i  (req),
        .slv_resp_o (resp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req  = '0;
        rst  = 1'b1;
        test = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_active_hs: got %b want 00000",
                     {resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid});
        end
        rst = 1'b0;
        n_cmp++;
        if ({resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_after_hs: got %b want 00000",
                     {resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid});
        end
        step();
        n_cmp++;
        if ({resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid} !== 5'b10100) begin
            n_fail++;
            $display("FAIL rst_released_hs: got %b want 10100",
                     {resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid});
        end
        n_cmp++;
        if ({resp.b.user, resp.r.user} !== 2'b00) begin
            n_fail++;
            $display("FAIL unused_user: got %b want 00", {resp.b.user, resp.r.user});
        end
    endtask

    task automatic test_single_read();
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd5;
        req.ar.len   = 8'd3;
        n_cmp++;
        if (resp.ar_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_ar_ready: got %b want 1", resp.ar_ready);
        end
        step();
        req.ar_valid = 1'b0;
        n_cmp++;
        if (resp.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_early_valid: got %b want 0", resp.r_valid);
        end
        step();
        req.r_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (resp.r_valid !== 1'b1 || resp.r.id !== 4'd5 || resp.r.data !== RDATA ||
                resp.r.resp !== 2'b11 || resp.r.last !== (i == 3)) begin
                n_fail++;
                $display("FAIL rd_beat%0d: got v=%b id=%h data=%h resp=%b last=%b want v=1 id=5 data=%h resp=11 last=%b",
                         i, resp.r_valid, resp.r.id, resp.r.data, resp.r.resp, resp.r.last, RDATA, (i == 3));
            end
            step();
        end
        req.r_ready = 1'b0;
        n_cmp++;
        if (resp.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_after_last: got %b want 0", resp.r_valid);
        end
    endtask

    task automatic test_write();
        n_cmp++;
        if (resp.w_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_w_ready_before_aw: got %b want 0", resp.w_ready);
        end
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd3;
        n_cmp++;
        if (resp.aw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_aw_ready: got %b want 1", resp.aw_ready);
        end
        step();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b1;
        req.w.last   = 1'b0;
        n_cmp++;
        if (resp.w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_w_ready_after_aw: got %b want 1", resp.w_ready);
        end
        step();
        req.w.last = 1'b1;
        n_cmp++;
        if (resp.b_valid !== 1'b0 || resp.w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_mid_burst: got b_valid=%b w_ready=%b want 0 1", resp.b_valid, resp.w_ready);
        end
        step();
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        n_cmp++;
        if (resp.b_valid !== 1'b1 || resp.b.id !== 4'd3 || resp.b.resp !== 2'b11) begin
            n_fail++;
            $display("FAIL wr_b: got v=%b id=%h resp=%b want v=1 id=3 resp=11",
                     resp.b_valid, resp.b.id, resp.b.resp);
        end
        req.b_ready = 1'b1;
        step();
        req.b_ready = 1'b0;
        n_cmp++;
        if (resp.b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_b_after_pop: got %b want 0", resp.b_valid);
        end
    endtask

    task automatic test_parallel();
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd2;
        req.ar.len   = 8'd0;
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd7;
        n_cmp++;
        if (resp.ar_ready !== 1'b1 || resp.aw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL par_readies: got ar=%b aw=%b want 1 1", resp.ar_ready, resp.aw_ready);
        end
        step();
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b1;
        req.w.last   = 1'b1;
        req.r_ready  = 1'b1;
        n_cmp++;
        if (resp.w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL par_w_ready: got %b want 1", resp.w_ready);
        end
        step();
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        n_cmp++;
        if (resp.r_valid !== 1'b1 || resp.r.id !== 4'd2 || resp.r.last !== 1'b1 || resp.r.resp !== 2'b11) begin
            n_fail++;
            $display("FAIL par_r_len0: got v=%b id=%h last=%b resp=%b want v=1 id=2 last=1 resp=11",
                     resp.r_valid, resp.r.id, resp.r.last, resp.r.resp);
        end
        n_cmp++;
        if (resp.b_valid !== 1'b1 || resp.b.id !== 4'd7 || resp.b.resp !== 2'b11) begin
            n_fail++;
            $display("FAIL par_b: got v=%b id=%h resp=%b want v=1 id=7 resp=11",
                     resp.b_valid, resp.b.id, resp.b.resp);
        end
        req.b_ready = 1'b1;
        step();
        req.b_ready = 1'b0;
        req.r_ready = 1'b0;
        n_cmp++;
        if (resp.r_valid !== 1'b0 || resp.b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL par_drained: got r_valid=%b b_valid=%b want 0 0", resp.r_valid, resp.b_valid);
        end
    endtask

    task automatic test_aw_full();
        logic [3:0] exp_id;
        for (int i = 0; i < 4; i++) begin
            req.aw_valid = 1'b1;
            req.aw.id    = 4'(i);
            n_cmp++;
            if (resp.aw_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL full_aw_ready%0d: got %b want 1", i, resp.aw_ready);
            end
            step();
        end
        req.aw.id   = 4'd4;
        req.w_valid = 1'b1;
        req.w.last  = 1'b1;
        n_cmp++;
        if (resp.aw_ready !== 1'b0 || resp.w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_refuse: got aw_ready=%b w_ready=%b want 0 1", resp.aw_ready, resp.w_ready);
        end
        step();
        req.w_valid = 1'b0;
        n_cmp++;
        if (resp.aw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_reassert: got %b want 1", resp.aw_ready);
        end
        step();
        req.aw_valid = 1'b0;
        req.b_ready  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_id      = 4'(k);
            req.w_valid = (k < 4);
            n_cmp++;
            if (resp.b_valid !== 1'b1 || resp.b.id !== exp_id || resp.w_ready !== (k < 4)) begin
                n_fail++;
                $display("FAIL full_drain%0d: got b_valid=%b id=%h w_ready=%b want 1 %h %b",
                         k, resp.b_valid, resp.b.id, resp.w_ready, exp_id, (k < 4));
            end
            step();
        end
        req.b_ready = 1'b0;
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        n_cmp++;
        if (resp.b_valid !== 1'b0 || resp.w_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty: got b_valid=%b w_ready=%b want 0 0", resp.b_valid, resp.w_ready);
        end
    endtask

    task automatic test_b_backpressure();
        logic [3:0] exp_id;
        req.b_ready  = 1'b0;
        req.aw_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req.aw.id = 4'(8 + i);
            step();
        end
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b1;
        req.w.last   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (resp.w_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bbp_w_ready%0d: got %b want 1", i, resp.w_ready);
            end
            step();
        end
        req.w_valid  = 1'b0;
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd12;
        n_cmp++;
        if (resp.aw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bbp_aw5_ready: got %b want 1", resp.aw_ready);
        end
        step();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (resp.w_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bbp_w_blocked%0d: got %b want 0", i, resp.w_ready);
            end
            if (i == 0) step();
        end
        n_cmp++;
        if (resp.b_valid !== 1'b1 || resp.b.id !== 4'd8) begin
            n_fail++;
            $display("FAIL bbp_b_first: got v=%b id=%h want v=1 id=8", resp.b_valid, resp.b.id);
        end
        req.b_ready = 1'b1;
        step();
        req.b_ready = 1'b0;
        n_cmp++;
        if (resp.w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bbp_w_unblocked: got %b want 1", resp.w_ready);
        end
        step();
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        req.b_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id = 4'(9 + k);
            n_cmp++;
            if (resp.b_valid !== 1'b1 || resp.b.id !== exp_id) begin
                n_fail++;
                $display("FAIL bbp_order%0d: got v=%b id=%h want v=1 id=%h", k, resp.b_valid, resp.b.id, exp_id);
            end
            step();
        end
        req.b_ready = 1'b0;
        n_cmp++;
        if (resp.b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bbp_drained: got %b want 0", resp.b_valid);
        end
    endtask

    task automatic test_r_backpressure();
        int beats   = 0;
        bit stalled = 1'b0;
        bit last_prev = 1'b0;
        bit done    = 1'b0;
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd9;
        req.ar.len   = 8'd255;
        step();
        req.ar_valid = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            req.r_ready = 1'($urandom_range(0, 1));
            if (stalled) begin
                n_cmp++;
                if (resp.r_valid !== 1'b1 || resp.r.last !== last_prev) begin
                    n_fail++;
                    $display("FAIL rbp_stable: got v=%b last=%b want v=1 last=%b", resp.r_valid, resp.r.last, last_prev);
                end
            end
            if (resp.r_valid === 1'b1) begin
                n_cmp++;
                if (resp.r.id !== 4'd9 || resp.r.data !== RDATA || resp.r.last !== (beats == 255)) begin
                    n_fail++;
                    $display("FAIL rbp_beat%0d: got id=%h data=%h last=%b want id=9 data=%h last=%b",
                             beats, resp.r.id, resp.r.data, resp.r.last, RDATA, (beats == 255));
                end
                if (req.r_ready) begin
                    beats++;
                    if (resp.r.last === 1'b1) done = 1'b1;
                end
                stalled   = !req.r_ready;
                last_prev = resp.r.last;
            end else begin
                stalled = 1'b0;
            end
            step();
        end
        req.r_ready = 1'b0;
        n_cmp++;
        if (beats != 256 || !done) begin
            n_fail++;
            $display("FAIL rbp_count: got %0d beats done=%b want 256 beats done=1", beats, done);
        end
        n_cmp++;
        if (resp.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rbp_idle: got %b want 0", resp.r_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd6;
        req.ar.len   = 8'd7;
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd1;
        step();
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b1;
        req.w.last   = 1'b1;
        step();
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        req.r_ready = 1'b1;
        n_cmp++;
        if (resp.r_valid !== 1'b1 || resp.b_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rmb_pre: got r_valid=%b b_valid=%b want 1 1", resp.r_valid, resp.b_valid);
        end
        step();
        n_cmp++;
        if (resp.r_valid !== 1'b1 || resp.r.last !== 1'b0) begin
            n_fail++;
            $display("FAIL rmb_beat2: got v=%b last=%b want 1 0", resp.r_valid, resp.r.last);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) step();
            else rst = 1'b0;
            n_cmp++;
            if ({resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid} !== 5'b0) begin
                n_fail++;
                $display("FAIL rmb_reset_hs%0d: got %b want 00000", i,
                         {resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid});
            end
        end
        req.b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({resp.aw_ready, resp.ar_ready, resp.b_valid, resp.r_valid} !== 4'b1100) begin
                n_fail++;
                $display("FAIL rmb_no_stale%0d: got %b want 1100", i,
                         {resp.aw_ready, resp.ar_ready, resp.b_valid, resp.r_valid});
            end
        end
        req.b_ready = 1'b0;
        req.r_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_parallel();
        test_aw_full();
        test_b_backpressure();
        test_r_backpressure();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
